// File: rtl/rv64g_l2_pkg.sv
// Shared widths, op encodings and sequencer state for the L2 line sequencer.
// Imported by the sequencer and its bench.
package rv64g_l2_pkg;

    localparam int IDX_W          = 8;
    localparam int WORD_W         = 3;
    localparam int WAY_W          = 4;
    localparam int TAG_W          = 50;
    localparam int DATA_W         = 64;
    localparam int BE_W           = DATA_W / 8;
    localparam int WORDS_PER_LINE = 8;

    localparam logic OP_FILL  = 1'b0;
    localparam logic OP_EVICT = 1'b1;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_EV_RD,
        ST_EV_OUT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rv64g_l2_line_seq.sv
// Line sequencer in front of the L2 arrays: refills one way from 8 beats,
// or reads a victim way out onto the writeback channel, one line at a time.
module rv64g_l2_line_seq
    import rv64g_l2_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_op_i,
    input  logic [IDX_W-1:0]  req_index_i,
    input  logic [WAY_W-1:0]  req_way_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    input  logic              fill_valid_i,
    output logic              fill_ready_o,
    input  logic [DATA_W-1:0] fill_data_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_last_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic              done_o,
    output logic [IDX_W-1:0]  arr_index_o,
    output logic [WORD_W-1:0] arr_word_sel_o,
    output logic [WAY_W-1:0]  arr_way_sel_o,
    output logic              arr_data_we_o,
    output logic              arr_tag_we_o,
    output logic [BE_W-1:0]   arr_be_o,
    output logic [TAG_W-1:0]  arr_tag_o,
    output logic [DATA_W-1:0] arr_wdata_o,
    input  logic [DATA_W-1:0] arr_rdata_i,
    input  logic [TAG_W-1:0]  arr_tag_i
);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  k_q, k_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TAG_W-1:0]   wbtag_q, wbtag_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            index_q <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            wbtag_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            index_q <= index_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            wbtag_q <= wbtag_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        index_d        = index_q;
        way_d          = way_q;
        tag_d          = tag_q;
        wbtag_d        = wbtag_q;
        req_ready_o    = 1'b0;
        fill_ready_o   = 1'b0;
        wb_valid_o     = 1'b0;
        wb_data_o      = '0;
        wb_last_o      = 1'b0;
        wb_tag_o       = wbtag_q;
        done_o         = 1'b0;
        arr_index_o    = index_q;
        arr_way_sel_o  = way_q;
        arr_word_sel_o = k_q;
        arr_data_we_o  = 1'b0;
        arr_tag_we_o   = 1'b0;
        arr_be_o       = '0;
        arr_tag_o      = '0;
        arr_wdata_o    = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    index_d = req_index_i;
                    way_d   = req_way_i;
                    tag_d   = req_tag_i;
                    k_d     = '0;
                    state_d = (req_op_i == OP_FILL) ? ST_FILL : ST_EV_RD;
                end
            end
            ST_FILL: begin
                fill_ready_o = 1'b1;
                if (fill_valid_i) begin
                    arr_data_we_o = 1'b1;
                    arr_be_o      = '1;
                    arr_wdata_o   = fill_data_i;
                    if (k_q == LAST_WORD) begin
                        arr_tag_we_o = 1'b1;
                        arr_tag_o    = tag_q;
                        state_d      = ST_DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_EV_RD: begin
                state_d = ST_EV_OUT;
            end
            ST_EV_OUT: begin
                wb_valid_o = 1'b1;
                wb_data_o  = arr_rdata_i;
                wb_last_o  = (k_q == LAST_WORD);
                // Word 0 shows the tag straight through so it is valid with the first beat
                if (k_q == '0) begin
                    wb_tag_o = arr_tag_i;
                    wbtag_d  = arr_tag_i;
                end
                if (wb_ready_i) begin
                    if (k_q == LAST_WORD) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_EV_RD;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rv64g_l2_line_seq.sv
// Bench for rv64g_l2_line_seq: behavioural array memory plus a line-level
// reference model checked every cycle, directed cases and random traffic.
module tb_rv64g_l2_line_seq;
    import rv64g_l2_pkg::*;

    logic              clk;
    logic              rst_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_op_i;
    logic [IDX_W-1:0]  req_index_i;
    logic [WAY_W-1:0]  req_way_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              fill_valid_i;
    logic              fill_ready_o;
    logic [DATA_W-1:0] fill_data_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_last_o;
    logic [TAG_W-1:0]  wb_tag_o;
    logic              done_o;
    logic [IDX_W-1:0]  arr_index_o;
    logic [WORD_W-1:0] arr_word_sel_o;
    logic [WAY_W-1:0]  arr_way_sel_o;
    logic              arr_data_we_o;
    logic              arr_tag_we_o;
    logic [BE_W-1:0]   arr_be_o;
    logic [TAG_W-1:0]  arr_tag_o;
    logic [DATA_W-1:0] arr_wdata_o;
    logic [DATA_W-1:0] arr_rdata_i;
    logic [TAG_W-1:0]  arr_tag_i;

    rv64g_l2_line_seq dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_index_i   (req_index_i),
        .req_way_i     (req_way_i),
        .req_tag_i     (req_tag_i),
        .fill_valid_i  (fill_valid_i),
        .fill_ready_o  (fill_ready_o),
        .fill_data_i   (fill_data_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_last_o     (wb_last_o),
        .wb_tag_o      (wb_tag_o),
        .done_o        (done_o),
        .arr_index_o   (arr_index_o),
        .arr_word_sel_o(arr_word_sel_o),
        .arr_way_sel_o (arr_way_sel_o),
        .arr_data_we_o (arr_data_we_o),
        .arr_tag_we_o  (arr_tag_we_o),
        .arr_be_o      (arr_be_o),
        .arr_tag_o     (arr_tag_o),
        .arr_wdata_o   (arr_wdata_o),
        .arr_rdata_i   (arr_rdata_i),
        .arr_tag_i     (arr_tag_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Array stand-in: registered read, one-cycle latency, no reset
    logic [63:0] amem [logic [14:0]];
    logic [49:0] atag [logic [11:0]];

    function automatic logic [63:0] a_rd(input logic [14:0] k);
        return amem.exists(k) ? amem[k] : 64'h0;
    endfunction
    function automatic logic [49:0] a_tg(input logic [11:0] k);
        return atag.exists(k) ? atag[k] : 50'h0;
    endfunction

    always @(posedge clk) begin
        logic [14:0] wk;
        logic [63:0] w;
        wk = {arr_index_o, arr_way_sel_o, arr_word_sel_o};
        if (arr_data_we_o) begin
            w = a_rd(wk);
            for (int b = 0; b < 8; b++)
                if (arr_be_o[b]) w[b*8 +: 8] = arr_wdata_o[b*8 +: 8];
            amem[wk] = w;
        end
        if (arr_tag_we_o) atag[{arr_index_o, arr_way_sel_o}] = arr_tag_o;
        arr_rdata_i <= a_rd(wk);
        arr_tag_i   <= a_tg({arr_index_o, arr_way_sel_o});
    end

    // Reference model: line contents and tags, plus an operation phase
    localparam int P_IDLE = 0, P_FILL = 1, P_EV = 2, P_DONE = 3;
    logic [63:0] emem [logic [14:0]];
    logic [49:0] etag [logic [11:0]];
    int          ph = P_IDLE;
    int          m_beat = 0;
    int          gap = 0;
    logic [7:0]  c_idx;
    logic [3:0]  c_way;
    logic [49:0] c_tag;
    int          we_cnt = 0;
    int          tag_we_cnt = 0;

    function automatic logic [63:0] e_rd(input logic [14:0] k);
        return emem.exists(k) ? emem[k] : 64'h0;
    endfunction
    function automatic logic [49:0] e_tg(input logic [11:0] k);
        return etag.exists(k) ? etag[k] : 50'h0;
    endfunction

    always @(negedge clk) begin
        logic hs;
        logic [14:0] k;
        if (!rst_ni) begin
            ph = P_IDLE;
            m_beat = 0;
            gap = 0;
        end else begin
            k = {c_idx, c_way, 3'(m_beat)};
            hs = (ph == P_FILL) && fill_valid_i;
            chk("req_ready", req_ready_o, ph == P_IDLE);
            chk("fill_ready", fill_ready_o, ph == P_FILL);
            chk("done", done_o, ph == P_DONE);
            chk("wb_valid", wb_valid_o, (ph == P_EV) && (gap == 0));
            chk("data_we", arr_data_we_o, hs);
            chk("tag_we", arr_tag_we_o, hs && (m_beat == 7));
            if (arr_data_we_o) we_cnt++;
            if (arr_tag_we_o) tag_we_cnt++;
            if (hs) begin
                chk("fill_word", arr_word_sel_o, m_beat);
                chk("fill_wdata", arr_wdata_o, fill_data_i);
                chk("fill_be", arr_be_o, 64'hff);
                chk("fill_index", arr_index_o, c_idx);
                chk("fill_way", arr_way_sel_o, c_way);
                if (m_beat == 7) chk("fill_tag", arr_tag_o, c_tag);
            end
            if (ph == P_EV) begin
                chk("ev_index", arr_index_o, c_idx);
                chk("ev_way", arr_way_sel_o, c_way);
                chk("ev_word", arr_word_sel_o, m_beat);
                if (gap == 0) begin
                    chk("wb_data", wb_data_o, e_rd(k));
                    chk("wb_last", wb_last_o, m_beat == 7);
                    chk("wb_tag", wb_tag_o, e_tg({c_idx, c_way}));
                end
            end
            case (ph)
                P_IDLE: if (req_valid_i) begin
                    c_idx = req_index_i;
                    c_way = req_way_i;
                    c_tag = req_tag_i;
                    m_beat = 0;
                    gap = 1;
                    ph = req_op_i ? P_EV : P_FILL;
                end
                P_FILL: if (fill_valid_i) begin
                    emem[k] = fill_data_i;
                    if (m_beat == 7) begin
                        etag[{c_idx, c_way}] = c_tag;
                        ph = P_DONE;
                    end else m_beat++;
                end
                P_EV: if (gap != 0) gap = 0;
                    else if (wb_ready_i) begin
                        if (m_beat == 7) ph = P_DONE;
                        else begin
                            m_beat++;
                            gap = 1;
                        end
                    end
                default: ph = P_IDLE;
            endcase
        end
    end

    // Stimulus
    logic [63:0] wbq [$];
    int          last_cyc;

    task automatic wait_idle();
        int n = 0;
        while (!req_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", req_ready_o, 1);
    endtask

    task automatic issue(input logic op, input logic [7:0] idx,
                         input logic [3:0] way, input logic [49:0] tag);
        wait_idle();
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_index_i = idx;
        req_way_i   = way;
        req_tag_i   = tag;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_op_i    = 1'($urandom);
        req_index_i = 8'($urandom);
        req_way_i   = 4'($urandom);
        req_tag_i   = {18'($urandom), $urandom};
    endtask

    task automatic do_fill(input logic [7:0] idx, input logic [3:0] way,
                           input logic [49:0] tag, input logic [63:0] base,
                           input int gap_at, input int gap_len,
                           input bit rnd, input int abort_after);
        int g;
        issue(OP_FILL, idx, way, tag);
        for (int b = 0; b < 8; b++) begin
            g = rnd ? (($urandom % 4 == 0) ? int'($urandom % 3) + 1 : 0)
                    : ((b == gap_at) ? gap_len : 0);
            for (int i = 0; i < g; i++) begin
                fill_valid_i = 1'b0;
                fill_data_i  = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            fill_valid_i = 1'b1;
            fill_data_i  = base + 64'(b);
            @(posedge clk); #1;
            fill_valid_i = 1'b0;
            if (b == abort_after) begin
                rst_ni = 1'b0;
                @(negedge clk);
                chk("abort_req_ready", req_ready_o, 1);
                chk("abort_done", done_o, 0);
                chk("abort_fill_ready", fill_ready_o, 0);
                chk("abort_data_we", arr_data_we_o, 0);
                @(posedge clk); #1;
                rst_ni = 1'b1;
                return;
            end
        end
        wait_idle();
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 5 cycles at beat 3
    task automatic do_evict(input logic [7:0] idx, input logic [3:0] way, input int mode);
        int beats = 0;
        int cyc = 0;
        int stall = 0;
        logic rdy;
        wbq.delete();
        last_cyc = -1;
        issue(OP_EVICT, idx, way, 50'h0);
        while (beats < 8 && cyc < 300) begin
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = 1'($urandom);
            else if (beats == 3 && wb_valid_o && stall < 5) begin
                rdy = 1'b0;
                stall++;
                chk("stall_data", wb_data_o, 64'h1003);
            end else rdy = 1'b1;
            wb_ready_i = rdy;
            @(negedge clk);
            if (wb_valid_o && wb_ready_i) begin
                wbq.push_back(wb_data_o);
                beats++;
                if (wb_last_o) last_cyc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        wb_ready_i = 1'b0;
        chk("ev_beats", beats, 8);
        wait_idle();
    endtask

    int we0, tw0;

    initial begin
        rst_ni       = 1'b0;
        req_valid_i  = 1'b0;
        req_op_i     = 1'b0;
        req_index_i  = '0;
        req_way_i    = '0;
        req_tag_i    = '0;
        fill_valid_i = 1'b0;
        fill_data_i  = '0;
        wb_ready_i   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_fill_ready", fill_ready_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_data_we", arr_data_we_o, 0);
        chk("rst_tag_we", arr_tag_we_o, 0);
        chk("rst_index", arr_index_o, 0);
        chk("rst_wb_tag", wb_tag_o, 0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Back-to-back fill
        we0 = we_cnt; tw0 = tag_we_cnt;
        do_fill(8'h10, 4'd5, 50'h123456789ABC, 64'h1000, -1, 0, 1'b0, -1);
        chk("fill_we_cnt", we_cnt - we0, 8);
        chk("fill_tagwe_cnt", tag_we_cnt - tw0, 1);
        chk("fill_word2", a_rd({8'h10, 4'd5, 3'd2}), 64'h1002);
        chk("fill_tagval", a_tg({8'h10, 4'd5}), 50'h123456789ABC);

        // Evict with ready high
        do_evict(8'h10, 4'd5, 0);
        chk("ev_latency", last_cyc + 1, 16);
        for (int i = 0; i < 8 && i < wbq.size(); i++)
            chk("ev_order", wbq[i], 64'h1000 + 64'(i));

        // Evict with backpressure at beat 3
        do_evict(8'h10, 4'd5, 2);
        chk("stall_cnt", wbq.size(), 8);
        for (int i = 0; i < 8 && i < wbq.size(); i++)
            chk("stall_order", wbq[i], 64'h1000 + 64'(i));

        // Fill with a 3-cycle gap after beat 4
        we0 = we_cnt; tw0 = tag_we_cnt;
        do_fill(8'h30, 4'd9, 50'h2_0000_0000_0055, 64'h5000, 5, 3, 1'b0, -1);
        chk("gap_we_cnt", we_cnt - we0, 8);
        chk("gap_tagwe_cnt", tag_we_cnt - tw0, 1);
        chk("gap_word5", a_rd({8'h30, 4'd9, 3'd5}), 64'h5005);
        chk("gap_word7", a_rd({8'h30, 4'd9, 3'd7}), 64'h5007);

        // Reset after beat 3 of a refill over an existing line
        do_fill(8'h20, 4'd1, 50'h0_AAAA_BBBB_CCCC, 64'h7000, -1, 0, 1'b0, -1);
        we0 = we_cnt; tw0 = tag_we_cnt;
        do_fill(8'h20, 4'd1, 50'h1_1111_2222_3333, 64'h9000, -1, 0, 1'b0, 3);
        chk("abort_we_cnt", we_cnt - we0, 4);
        chk("abort_tagwe_cnt", tag_we_cnt - tw0, 0);
        chk("abort_tag", a_tg({8'h20, 4'd1}), 50'h0_AAAA_BBBB_CCCC);
        chk("abort_word3", a_rd({8'h20, 4'd1, 3'd3}), 64'h9003);
        chk("abort_word4", a_rd({8'h20, 4'd1, 3'd4}), 64'h7004);
        do_evict(8'h20, 4'd1, 1);

        // Random traffic over a small set of lines
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ri;
            logic [3:0] rw;
            ri = 8'h40 + 8'($urandom % 3);
            rw = 4'($urandom % 3);
            if ($urandom % 2 == 0)
                do_fill(ri, rw, {18'($urandom), $urandom}, {$urandom, $urandom},
                        -1, 0, 1'b1, -1);
            else
                do_evict(ri, rw, 1);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

endmodule
